motion_arbiter: RTL and testbench
=================================

Name: motion_arbiter

Overview:
- Sits between the three mode controllers (semi-auto, auto, manual) and the simulated-device motion/barrier inputs.
- Selects the active requester by mode and filters contradictory commands.
- Sequences safe transitions: dead time on mode change, stop gap on forward/backward reversal.
- Turns level barrier requests into rate-limited single-cycle pulses.

Parameters:
- SWITCH_CYCLES, 8, forced all-zero cycles after entering a non-off mode (>=1)
- REV_GAP, 4, forced all-zero cycles on a forward/backward reversal (>=1)
- BARRIER_GAP, 16, minimum cycles between two barrier pulses (>=1)
- WDOG_CYCLES, 1024, watchdog limit for continuous motion (optional feature only)
- CNT_W, 16, width of internal counters; must hold the largest of the above

Ports:
- clk  in  1  system tick (divided clock)
- reset  in  1  asynchronous, active-low; 0 = reset
- mode  in  2  11 semi, 10 auto, 01 manual, 00 off
- req_semi  in  6  {fwd, back, left, right, place, destroy}; place/destroy are ignored for semi
- req_auto  in  6  same packing
- req_man  in  6  same packing
- move_forward, move_backward, turn_left, turn_right  out  1 each  registered motion outputs
- place_barrier, destroy_barrier  out  1 each  registered single-cycle pulses
- arb_state  out  2  IDLE 00, SWITCH 01, RUN 10, REVERSE 11

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; mode_q=00; last_dir=NONE; counters 0; barrier lockout 0.
- mode_q captures mode every edge. If mode != mode_q:
  - new mode 00 -> IDLE.
  - otherwise -> SWITCH, cnt=SWITCH_CYCLES-1.
  - In both cases last_dir=NONE and outputs are registered 0.
  - Takes priority over every other transition. A mode change during SWITCH restarts the count.
- IDLE: all outputs 0. Leaves only through a mode change.
- SWITCH: outputs 0; cnt decrements each edge; at cnt==0 -> RUN.
- RUN: every edge outputs <= filtered request of the selected source (1-cycle latency).
- Filtering:
  - fwd&back both 1 -> both 0.
  - left&right both 1 -> both 0.
  - semi back/place/destroy forced 0.
- Reversal:
  - last_dir records FWD or BACK whenever move_forward/move_backward is registered 1.
  - In RUN, a filtered request of back=1 with last_dir=FWD (or fwd=1 with last_dir=BACK) -> REVERSE, cnt=REV_GAP-1, all outputs 0, last_dir=NONE.
- REVERSE: outputs 0; cnt decrements; at cnt==0 -> RUN.
- Barrier:
  - Rising-edge detect on the selected place/destroy bits, edge history kept every cycle in all states.
  - In RUN only, with lockout==0, a single rising edge produces a 1-cycle pulse on the matching output and loads lockout=BARRIER_GAP-1.
  - Simultaneous place and destroy edges -> no pulse, no lockout.
  - lockout decrements to 0 in every state.
  - Edges outside RUN or during lockout are dropped, not queued.
- The barrier edge history is cleared on a mode change.

Optional Feature:
- Macro MOTION_ARBITER_WATCHDOG_EN.
- With it: in RUN, a counter counts consecutive cycles with any motion output at 1. On reaching WDOG_CYCLES, all motion outputs are forced 0 and a latched trip flag is set. The flag clears only when the filtered motion request is all-zero for one cycle, or on mode change or reset. The counter clears whenever all motion outputs are 0.
- Without it: no counter or flag; motion is unlimited.

Test Plan:
- Reset 0 for 3 cycles, then release with mode=00 and req_man=6'b111111 -> all outputs 0, arb_state=00.
- mode 00->01 with req_man=100000 -> arb_state 01 for 8 edges. move_forward first 1 on edge 10 after the capturing edge: 8 SWITCH edges, +1 entering RUN, +1 output register.
- RUN manual, fwd held, then req_man=010000 -> REVERSE, 4 edges of zeros, then move_backward=1. fwd+back together (110000) -> both 0 with no REVERSE.
- Mode 01->10 mid-RUN while auto requests fwd -> outputs 0 the next edge, SWITCH restarts for 8 edges. Change to 11 at edge 3 of SWITCH -> count restarts at 8.
- Auto place toggled 0->1 twice, 5 cycles apart -> exactly one 1-cycle place_barrier pulse. Third edge 16+ cycles after the first -> second pulse. place+destroy rising together -> no pulse.
- With MOTION_ARBITER_WATCHDOG_EN and WDOG_CYCLES=10: fwd held 15 cycles -> move_forward drops after 10 high cycles. Release for 1 cycle, then re-press -> move_forward resumes.

Source files
------------

// File: rtl/motion_arbiter.sv
// motion_arbiter: picks the active mode controller, filters contradictory
// motion requests, inserts dead time on mode changes and on forward/backward
// reversals, and turns level barrier requests into rate-limited pulses.
// Optional continuous-motion watchdog: define MOTION_ARBITER_WATCHDOG_EN.
// Request packing (all sources): {fwd, back, left, right, place, destroy}.
module motion_arbiter #(
    parameter int SWITCH_CYCLES = 8,
    parameter int REV_GAP       = 4,
    parameter int BARRIER_GAP   = 16,
    parameter int WDOG_CYCLES   = 1024,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic [5:0] req_semi,
    input  logic [5:0] req_auto,
    input  logic [5:0] req_man,
    output logic       move_forward,
    output logic       move_backward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       place_barrier,
    output logic       destroy_barrier,
    output logic [1:0] arb_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SWITCH  = 2'b01,
        RUN     = 2'b10,
        REVERSE = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_FWD  = 2'b01,
        DIR_BACK = 2'b10
    } dir_t;

    localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] REV_LOAD    = CNT_W'(REV_GAP - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(BARRIER_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       mode_q;
    dir_t             last_dir;
    dir_t             last_dir_next;
    logic [CNT_W-1:0] lockout;
    logic [CNT_W-1:0] lockout_next;
    logic [1:0]       hist;
    logic [1:0]       hist_next;
    logic [3:0]       motion;
    logic [3:0]       motion_next;
    logic             place_next;
    logic             destroy_next;
    logic [5:0]       sel;
    logic [5:0]       filt;
    logic             mode_chg;
    logic             rev_hit;
    logic             run_ok;
    logic [1:0]       rise;
    logic             fire;
    logic             trip_next;

    assign mode_chg = (mode != mode_q);

    // Select the requester for the current mode and drop contradictory pairs
    always_comb begin
        sel = 6'b000000;
        case (mode)
            // Semi-auto has no backward or barrier control: those bits are
            // treated as absent, so a stray back bit cannot cancel fwd.
            2'b11:   sel = req_semi & 6'b101100;
            2'b10:   sel = req_auto;
            2'b01:   sel = req_man;
            default: sel = 6'b000000;
        endcase
        filt = sel;
        if (sel[5] && sel[4]) begin
            filt[5:4] = 2'b00;
        end
        if (sel[3] && sel[2]) begin
            filt[3:2] = 2'b00;
        end
    end

    // A request for the opposite longitudinal direction needs a stop gap
    assign rev_hit = (filt[4] && (last_dir == DIR_FWD)) ||
                     (filt[5] && (last_dir == DIR_BACK));

    // Outputs may follow the request only on an undisturbed RUN cycle
    assign run_ok = !mode_chg && (state == RUN) && !rev_hit;

`ifdef MOTION_ARBITER_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;
    logic             trip;
    logic             wd_expire;

    // Trip once motion has been high for WDOG_CYCLES consecutive cycles
    always_comb begin
        wd_expire = (|motion) && (wd_cnt >= WDOG_LAST);
        trip_next = trip;
        if (mode_chg || (filt[5:2] == 4'b0000)) begin
            trip_next = 1'b0;
        end else if ((state == RUN) && wd_expire) begin
            trip_next = 1'b1;
        end
    end

    // Count consecutive cycles with any motion output high; hold the trip
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
            trip   <= 1'b0;
        end else begin
            trip   <= trip_next;
            wd_cnt <= (|motion) ? (wd_cnt + CNT_ONE) : '0;
        end
    end
`else
    logic [CNT_W-1:0] wdog_unused;

    assign trip_next   = 1'b0;
    assign wdog_unused = CNT_W'(WDOG_CYCLES);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: a mode change overrides everything else
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (mode_chg) begin
            if (mode == 2'b00) begin
                state_next = IDLE;
                cnt_next   = '0;
            end else begin
                state_next = SWITCH;
                cnt_next   = SWITCH_LOAD;
            end
        end else begin
            case (state)
                SWITCH, REVERSE: begin
                    if (cnt == '0) begin
                        state_next = RUN;
                    end else begin
                        cnt_next = cnt - CNT_ONE;
                    end
                end
                RUN: begin
                    if (rev_hit) begin
                        state_next = REVERSE;
                        cnt_next   = REV_LOAD;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    // Output logic: next values of motion, barrier pulses and their history
    always_comb begin
        motion_next = run_ok && !trip_next ? filt[5:2] : 4'b0000;

        rise = filt[1:0] & ~hist;
        fire = run_ok && (lockout == '0) && (rise == 2'b10 || rise == 2'b01);
        place_next   = fire && rise[1];
        destroy_next = fire && rise[0];

        if (fire) begin
            lockout_next = GAP_LOAD;
        end else if (lockout != '0) begin
            lockout_next = lockout - CNT_ONE;
        end else begin
            lockout_next = '0;
        end

        hist_next = mode_chg ? 2'b00 : filt[1:0];

        last_dir_next = last_dir;
        if (mode_chg || ((state == RUN) && rev_hit)) begin
            last_dir_next = DIR_NONE;
        end else if (motion_next[3]) begin
            last_dir_next = DIR_FWD;
        end else if (motion_next[2]) begin
            last_dir_next = DIR_BACK;
        end
    end

    // Registered outputs and arbitration bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q          <= 2'b00;
            last_dir        <= DIR_NONE;
            lockout         <= '0;
            hist            <= 2'b00;
            motion          <= 4'b0000;
            place_barrier   <= 1'b0;
            destroy_barrier <= 1'b0;
        end else begin
            mode_q          <= mode;
            last_dir        <= last_dir_next;
            lockout         <= lockout_next;
            hist            <= hist_next;
            motion          <= motion_next;
            place_barrier   <= place_next;
            destroy_barrier <= destroy_next;
        end
    end

    assign move_forward  = motion[3];
    assign move_backward = motion[2];
    assign turn_left     = motion[1];
    assign turn_right    = motion[0];
    assign arb_state     = state;

    // Output invariants: no contradictory pairs, nothing active outside RUN
    assert property (@(posedge clk) disable iff (!reset)
        !(move_forward && move_backward));
    assert property (@(posedge clk) disable iff (!reset)
        !(turn_left && turn_right));
    assert property (@(posedge clk) disable iff (!reset)
        !(place_barrier && destroy_barrier));
    assert property (@(posedge clk) disable iff (!reset)
        (arb_state != RUN) |-> ((motion == 4'b0000) && !place_barrier && !destroy_barrier));
    assert property (@(posedge clk) disable iff (!reset)
        place_barrier |=> !place_barrier);

endmodule

// File: tb/tb_motion_arbiter.sv
// Self-checking bench for motion_arbiter: directed scenarios plus a random
// soak, all compared against a timestamp-based behavioural model.
module tb_motion_arbiter;

    localparam int SW = 8;
    localparam int RG = 4;
    localparam int BG = 16;
    localparam int WD = 10;

    localparam int P_IDLE   = 0;
    localparam int P_SWITCH = 1;
    localparam int P_RUN    = 2;
    localparam int P_REV    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [5:0] req_semi = 6'b0;
    logic [5:0] req_auto = 6'b0;
    logic [5:0] req_man = 6'b0;
    logic       mf, mb, tl, tr, pb, db;
    logic [1:0] arb_state;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    int         m_cyc = 0;
    int         m_phase = P_IDLE;
    int         m_enter = 0;
    int         m_dir = 0;          // 0 none, 1 forward, 2 backward
    int         m_last = -1000;     // cycle of the last barrier pulse
    logic [1:0] m_mode = 2'b00;
    logic [1:0] m_hist = 2'b00;
    logic [3:0] m_out = 4'b0;
    logic       m_pl = 1'b0;
    logic       m_de = 1'b0;
`ifdef MOTION_ARBITER_WATCHDOG_EN
    int         m_high = 0;
    logic       m_trip = 1'b0;
`endif

    motion_arbiter #(
        .SWITCH_CYCLES(SW),
        .REV_GAP(RG),
        .BARRIER_GAP(BG),
        .WDOG_CYCLES(WD),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .req_semi(req_semi),
        .req_auto(req_auto),
        .req_man(req_man),
        .move_forward(mf),
        .move_backward(mb),
        .turn_left(tl),
        .turn_right(tr),
        .place_barrier(pb),
        .destroy_barrier(db),
        .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    wire [7:0] dut_vec = {arb_state, mf, mb, tl, tr, pb, db};

    function automatic logic [7:0] model_vec();
        return {2'(m_phase), m_out, m_pl, m_de};
    endfunction

    function automatic logic [5:0] req_for(input logic [1:0] md, input logic [5:0] s,
                                           input logic [5:0] a, input logic [5:0] m);
        logic [5:0] r;
        case (md)
            2'b11:   r = {s[5], 1'b0, s[3], s[2], 2'b00};
            2'b10:   r = a;
            2'b01:   r = m;
            default: r = 6'b0;
        endcase
        if (r[5] && r[4]) r[5:4] = 2'b00;
        if (r[3] && r[2]) r[3:2] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_enter = 0;
        m_dir   = 0;
        m_last  = m_cyc - 1000;
        m_mode  = 2'b00;
        m_hist  = 2'b00;
        m_out   = 4'b0;
        m_pl    = 1'b0;
        m_de    = 1'b0;
`ifdef MOTION_ARBITER_WATCHDOG_EN
        m_high  = 0;
        m_trip  = 1'b0;
`endif
    endtask

    task automatic model_step();
        logic [5:0] f;
        logic [1:0] rise;
        logic       chg;
        logic       blocked;
        f    = req_for(mode, req_semi, req_auto, req_man);
        chg  = (mode != m_mode);
        m_mode = mode;
        rise = f[1:0] & ~m_hist;
        m_hist = chg ? 2'b00 : f[1:0];
        m_pl = 1'b0;
        m_de = 1'b0;
        blocked = 1'b0;
`ifdef MOTION_ARBITER_WATCHDOG_EN
        m_high = (m_out != 4'b0) ? m_high + 1 : 0;
        if (chg || f[5:2] == 4'b0) m_trip = 1'b0;
        else if (m_phase == P_RUN && m_high >= WD) m_trip = 1'b1;
        blocked = m_trip;
`endif
        if (chg) begin
            m_phase = (mode == 2'b00) ? P_IDLE : P_SWITCH;
            m_enter = m_cyc;
            m_dir   = 0;
            m_out   = 4'b0;
        end else if (m_phase == P_SWITCH || m_phase == P_REV) begin
            m_out = 4'b0;
            if (m_cyc - m_enter == ((m_phase == P_SWITCH) ? SW : RG)) m_phase = P_RUN;
        end else if (m_phase == P_RUN) begin
            if ((f[4] && m_dir == 1) || (f[5] && m_dir == 2)) begin
                m_phase = P_REV;
                m_enter = m_cyc;
                m_dir   = 0;
                m_out   = 4'b0;
            end else begin
                m_out = blocked ? 4'b0 : f[5:2];
                if (m_out[3]) m_dir = 1;
                else if (m_out[2]) m_dir = 2;
                if ((m_cyc - m_last >= BG) && (rise == 2'b10 || rise == 2'b01)) begin
                    m_pl   = rise[1];
                    m_de   = rise[0];
                    m_last = m_cyc;
                end
            end
        end else begin
            m_out = 4'b0;
        end
        m_cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mode = 2'b00;
        req_man = 6'b111111;
        #2;
        reset = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (dut_vec !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold: got %b expected %b", dut_vec, 8'h00);
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            n_cmp++;
            if (dut_vec !== 8'h00) begin
                n_bad++;
                $display("FAIL idle_after_reset: got %b expected %b", dut_vec, 8'h00);
            end
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL idle_model: got %b expected %b", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_switch();
        req_man = 6'b100000;
        mode = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            n_cmp++;
            if (arb_state !== 2'b01 || mf !== 1'b0) begin
                n_bad++;
                $display("FAIL switch_edge%0d: got state=%b fwd=%b expected state=01 fwd=0", e, arb_state, mf);
            end
        end
        tick();
        n_cmp++;
        if (arb_state !== 2'b10 || mf !== 1'b0) begin
            n_bad++;
            $display("FAIL switch_enter_run: got state=%b fwd=%b expected state=10 fwd=0", arb_state, mf);
        end
        tick();
        n_cmp++;
        if (mf !== 1'b1) begin
            n_bad++;
            $display("FAIL switch_first_fwd: got %b expected 1", mf);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("FAIL switch_model: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_reversal();
        repeat (2) tick();
        req_man = 6'b010000;
        for (int e = 0; e < RG; e++) begin
            tick();
            n_cmp++;
            if (arb_state !== 2'b11 || dut_vec[5:0] !== 6'b0) begin
                n_bad++;
                $display("FAIL reverse_gap%0d: got %b expected state=11 outputs=0", e, dut_vec);
            end
        end
        tick();
        n_cmp++;
        if (arb_state !== 2'b10 || mb !== 1'b0) begin
            n_bad++;
            $display("FAIL reverse_back_to_run: got %b expected state=10 outputs=0", dut_vec);
        end
        tick();
        n_cmp++;
        if (dut_vec !== 8'b10_0100_00) begin
            n_bad++;
            $display("FAIL reverse_backward: got %b expected %b", dut_vec, 8'b10_0100_00);
        end
        req_man = 6'b110000;
        tick();
        n_cmp++;
        if (dut_vec !== 8'b10_0000_00) begin
            n_bad++;
            $display("FAIL fwd_back_filter: got %b expected %b", dut_vec, 8'b10_0000_00);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_bad++;
            $display("FAIL reversal_model: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_mode_change();
        req_man = 6'b001000;
        repeat (2) tick();
        n_cmp++;
        if (dut_vec !== 8'b10_0010_00) begin
            n_bad++;
            $display("FAIL left_in_run: got %b expected %b", dut_vec, 8'b10_0010_00);
        end
        req_auto = 6'b100000;
        mode = 2'b10;
        tick();
        n_cmp++;
        if (dut_vec !== 8'b01_0000_00) begin
            n_bad++;
            $display("FAIL mode_change_zero: got %b expected %b", dut_vec, 8'b01_0000_00);
        end
        repeat (2) tick();
        req_semi = 6'b100000;
        mode = 2'b11;
        for (int e = 0; e < SW; e++) begin
            tick();
            n_cmp++;
            if (arb_state !== 2'b01) begin
                n_bad++;
                $display("FAIL restart_switch%0d: got %b expected 01", e, arb_state);
            end
        end
        tick();
        n_cmp++;
        if (arb_state !== 2'b10) begin
            n_bad++;
            $display("FAIL restart_run: got %b expected 10", arb_state);
        end
        tick();
        n_cmp++;
        if (dut_vec !== model_vec() || mf !== 1'b1) begin
            n_bad++;
            $display("FAIL semi_fwd: got %b expected %b", dut_vec, model_vec());
        end
    endtask

    task automatic test_barrier();
        int pulses;
        req_auto = 6'b0;
        mode = 2'b10;
        repeat (12) tick();
        req_auto = 6'b000010;
        tick();
        n_cmp++;
        if (pb !== 1'b1 || db !== 1'b0) begin
            n_bad++;
            $display("FAIL place_pulse1: got pb=%b db=%b expected pb=1 db=0", pb, db);
        end
        pulses = 0;
        for (int t = 1; t <= 15; t++) begin
            if (t == 2) req_auto = 6'b0;
            if (t == 5) req_auto = 6'b000010;
            if (t == 7) req_auto = 6'b0;
            tick();
            if (pb) pulses++;
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL barrier_model_t%0d: got %b expected %b", t, dut_vec, model_vec());
            end
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL lockout_drop: got %0d pulses expected 0", pulses);
        end
        req_auto = 6'b000010;
        tick();
        n_cmp++;
        if (pb !== 1'b1) begin
            n_bad++;
            $display("FAIL place_pulse2: got %b expected 1", pb);
        end
        tick();
        n_cmp++;
        if (pb !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_single: got %b expected 0", pb);
        end
        req_auto = 6'b0;
        repeat (20) tick();
        req_auto = 6'b000011;
        pulses = 0;
        repeat (3) begin
            tick();
            if (pb || db) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_bad++;
            $display("FAIL simultaneous_edges: got %0d pulses expected 0", pulses);
        end
        req_auto = 6'b000001;
        req_auto = 6'b0;
        tick();
        req_auto = 6'b000001;
        tick();
        n_cmp++;
        if (db !== 1'b1 || pb !== 1'b0) begin
            n_bad++;
            $display("FAIL destroy_pulse: got pb=%b db=%b expected pb=0 db=1", pb, db);
        end
    endtask

`ifdef MOTION_ARBITER_WATCHDOG_EN
    task automatic test_watchdog();
        int high;
        req_man = 6'b100000;
        mode = 2'b01;
        repeat (10) tick();
        high = mf ? 1 : 0;
        repeat (14) begin
            tick();
            if (mf) high++;
        end
        n_cmp++;
        if (high !== WD || mf !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_trip: got %0d high cycles (fwd=%b) expected %0d (fwd=0)", high, mf, WD);
        end
        req_man = 6'b0;
        tick();
        req_man = 6'b100000;
        tick();
        n_cmp++;
        if (mf !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_resume: got %b expected 1", mf);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) req_semi = 6'($urandom);
            if ($urandom_range(0, 9) == 0) req_auto = 6'($urandom);
            if ($urandom_range(0, 9) == 0) req_man = 6'($urandom);
            tick();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL random_c%0d: got %b expected %b", i, dut_vec, model_vec());
            end
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset: got %b expected %b", dut_vec, 8'h00);
        end
        tick();
        reset = 1'b1;
        repeat (2) begin
            tick();
            n_cmp++;
            if (dut_vec !== model_vec()) begin
                n_bad++;
                $display("FAIL post_reset_model: got %b expected %b", dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_reversal();
        test_mode_change();
        test_barrier();
`ifdef MOTION_ARBITER_WATCHDOG_EN
        test_watchdog();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
